// File: rtl/duart_pkg.sv
// Shared types and constants for the DUART transmit/receive channels.
package duart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int   BITS_BASE     = 5;
  localparam logic TX_IDLE_LEVEL = 1'b1;

  // Frame format captured when a character moves into the shift register.
  typedef struct packed {
    logic [1:0] bits;
    logic       par_en;
    logic       stop2;
    logic       par_bit;
  } frame_cfg_t;

  // Parity over the active data bits; odd parity inverts the XOR.
  function automatic logic tx_parity(input logic [7:0] d, input logic [1:0] bits,
                                     input logic odd);
    logic [7:0] mask;
    mask = 8'hFF >> (3'd3 - {1'b0, bits});
    return (^(d & mask)) ^ odd;
  endfunction

endpackage

// File: rtl/duart_tx_channel_if.sv
// CPU bus strobe, frame configuration and status for one transmit channel.
interface duart_tx_channel_if;
  logic       CS;
  logic       R_W;
  logic [7:0] DATA;
  logic       TX_ENA;
  logic       TX_DIS;
  logic [1:0] BITS;
  logic       PAR_EN;
  logic       PAR_ODD;
  logic       STOP2;
  logic       TxRDY;
  logic       TxEMT;

  modport master (
    output CS, R_W, DATA, TX_ENA, TX_DIS, BITS, PAR_EN, PAR_ODD, STOP2,
    input  TxRDY, TxEMT
  );

  modport slave (
    input  CS, R_W, DATA, TX_ENA, TX_DIS, BITS, PAR_EN, PAR_ODD, STOP2,
    output TxRDY, TxEMT
  );
endinterface

// File: rtl/duart_bit_timer.sv
// Purpose: counts BAUD16 ticks and flags the OVERSAMPLE-th one as bit_done.
// Latency: bit_done is combinational with the terminal tick; clear restarts the count.
// Backpressure: none; without ticks the count simply holds.
module duart_bit_timer #(
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic bit_done
);
  localparam int CW = $clog2(OVERSAMPLE);

  logic [CW-1:0] cnt;
  logic          at_end;

  assign at_end   = (cnt == CW'(OVERSAMPLE - 1));
  assign bit_done = tick & at_end;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= at_end ? '0 : cnt + CW'(1);
    end
  end
endmodule

// File: rtl/duart_tx_channel.sv
// Purpose: THR + TSR transmitter serialising async frames on TxD with TxRDY/TxEMT status.
// Latency: THR->TSR transfer one CLK after load; status registered one CLK behind its cause.
// Backpressure: writes while the THR is full or the channel is disabled are dropped.
module duart_tx_channel
  import duart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic                CLK,
  input  logic                RESET,
  duart_tx_channel_if.slave   bus,
  input  logic                BAUD16,
  output logic                TxD
);
  tx_state_t  state, state_n;
  logic [7:0] thr, tsr, tsr_n;
  logic       thr_full;
  logic       enabled;
  logic       wr_q, wr;
  logic [2:0] bit_cnt, bit_cnt_n;
  frame_cfg_t cfg;
  logic       bit_done, last_data, last_stop, transfer;
  logic       txd_n;
  logic       tx_rdy, tx_emt;

  assign wr        = bus.CS & ~bus.R_W & ~wr_q;
  assign last_data = (bit_cnt == ({1'b0, cfg.bits} + 3'(BITS_BASE - 1)));
  assign last_stop = (bit_cnt == {2'b00, cfg.stop2});
  // A pending character leaves the THR from IDLE or straight out of the final stop bit.
  assign transfer  = thr_full &
                     ((state == IDLE) || ((state == STOP) && bit_done && last_stop));

  duart_bit_timer #(.OVERSAMPLE(OVERSAMPLE)) u_timer (
    .clk      (CLK),
    .rst      (RESET),
    .clear    (transfer),
    .tick     (BAUD16),
    .bit_done (bit_done)
  );

  always_comb begin
    state_n   = state;
    tsr_n     = tsr;
    bit_cnt_n = bit_cnt;
    if (transfer) begin
      state_n   = START;
      tsr_n     = thr;
      bit_cnt_n = '0;
    end else if (bit_done) begin
      unique case (state)
        START: begin
          state_n   = DATA;
          bit_cnt_n = '0;
        end
        DATA: begin
          tsr_n = tsr >> 1;
          if (last_data) begin
            state_n   = cfg.par_en ? PARITY : STOP;
            bit_cnt_n = '0;
          end else begin
            bit_cnt_n = bit_cnt + 3'd1;
          end
        end
        PARITY: begin
          state_n   = STOP;
          bit_cnt_n = '0;
        end
        STOP: begin
          if (last_stop) state_n = IDLE;
          else           bit_cnt_n = bit_cnt + 3'd1;
        end
        default: ;
      endcase
    end

    // TxD is registered from the next state so the line tracks the FSM edge-for-edge.
    unique case (state_n)
      START:   txd_n = 1'b0;
      DATA:    txd_n = tsr_n[0];
      PARITY:  txd_n = cfg.par_bit;
      default: txd_n = TX_IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      tsr      <= '0;
      thr      <= '0;
      thr_full <= 1'b0;
      enabled  <= 1'b0;
      wr_q     <= 1'b0;
      bit_cnt  <= '0;
      cfg      <= '0;
      TxD      <= TX_IDLE_LEVEL;
      tx_rdy   <= 1'b0;
      tx_emt   <= 1'b0;
    end else begin
      state   <= state_n;
      tsr     <= tsr_n;
      bit_cnt <= bit_cnt_n;
      TxD     <= txd_n;
      wr_q    <= bus.CS & ~bus.R_W;

      if (bus.TX_DIS)      enabled <= 1'b0;
      else if (bus.TX_ENA) enabled <= 1'b1;

      if (transfer) begin
        thr_full    <= 1'b0;
        cfg.bits    <= bus.BITS;
        cfg.par_en  <= bus.PAR_EN;
        cfg.stop2   <= bus.STOP2;
        cfg.par_bit <= tx_parity(thr, bus.BITS, bus.PAR_ODD);
      end else if (wr && enabled && !thr_full) begin
        thr      <= bus.DATA;
        thr_full <= 1'b1;
      end

      tx_rdy <= enabled & ~thr_full;
      tx_emt <= enabled & ~thr_full & (state == IDLE);
    end
  end

  assign bus.TxRDY = tx_rdy;
  assign bus.TxEMT = tx_emt;
endmodule

// File: tb/tb_duart_tx_channel.sv
// Scoreboarded bench: expected frames are queued at write time and a line monitor decodes TxD.
module tb_duart_tx_channel;
  localparam int BIT_CLKS = 64;  // 16 BAUD16 ticks, one tick every 4 CLK

  typedef struct {
    logic [7:0] data;
    int         nbits;
    bit         par_en;
    bit         par_odd;
    bit         stop2;
    bit         b2b;
    int         exp_run;
  } frame_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic baud16 = 1'b0;
  logic TxD;
  int   n_cmp = 0;
  int   n_fail = 0;
  bit   mon_abort = 1'b0;
  bit   mon_busy = 1'b0;
  frame_t exp_q[$];

  duart_tx_channel_if bus ();

  duart_tx_channel #(.OVERSAMPLE(16)) dut (
    .CLK    (clk),
    .RESET  (rst),
    .bus    (bus),
    .BAUD16 (baud16),
    .TxD    (TxD)
  );

  always #5 clk = ~clk;

  initial begin
    int b;
    b = 0;
    forever begin
      @(negedge clk);
      b = (b + 1) % 4;
      baud16 = (b == 0);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Line image of a frame: start, LSB-first data, optional parity, stop bit(s).
  function automatic void frame_bits(input frame_t f, output logic [15:0] v, output int len);
    int ones;
    v = '0; len = 1; ones = 0;
    for (int i = 0; i < f.nbits; i++) begin
      v[len] = f.data[i];
      ones += int'(f.data[i]);
      len++;
    end
    if (f.par_en) begin
      v[len] = f.par_odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
      len++;
    end
    v[len] = 1'b1; len++;
    if (f.stop2) begin v[len] = 1'b1; len++; end
  endfunction

  function automatic int trailing_ones(input frame_t f);
    logic [15:0] v;
    int len, n;
    frame_bits(f, v, len);
    n = 0;
    for (int i = len - 1; i > 0 && v[i]; i--) n++;
    return n;
  endfunction

  function automatic frame_t make_frame(input logic [7:0] d, input bit b2b, input frame_t prev);
    frame_t f;
    f.data    = d;
    f.nbits   = 5 + int'(bus.BITS);
    f.par_en  = bus.PAR_EN;
    f.par_odd = bus.PAR_ODD;
    f.stop2   = bus.STOP2;
    f.b2b     = b2b;
    f.exp_run = b2b ? trailing_ones(prev) * BIT_CLKS : 0;
    return f;
  endfunction

  function automatic int frame_len(input frame_t f);
    return 2 + f.nbits + int'(f.par_en) + int'(f.stop2);
  endfunction

  task automatic set_cfg(input logic [1:0] bits, input bit pe, input bit po, input bit s2);
    bus.BITS = bits; bus.PAR_EN = pe; bus.PAR_ODD = po; bus.STOP2 = s2;
  endtask

  task automatic wr_char(input logic [7:0] d, input int hold);
    bus.CS = 1'b1; bus.R_W = 1'b0; bus.DATA = d;
    tick(hold);
    bus.CS = 1'b0; bus.R_W = 1'b1;
  endtask

  task automatic pulse_ena_dis(input bit ena, input bit dis);
    bus.TX_ENA = ena; bus.TX_DIS = dis;
    tick(1);
    bus.TX_ENA = 1'b0; bus.TX_DIS = 1'b0;
  endtask

  // Line monitor: finds each start edge, samples mid-bit and scores against the queue.
  initial begin
    logic prev_txd;
    logic [15:0] ev, rx, mask;
    int elen, cnt, k, hi_run;
    frame_t cur;
    prev_txd = 1'b1; hi_run = 0; cnt = 0; k = 0; elen = 10; ev = '0; rx = '0;
    forever begin
      @(negedge clk);
      if (mon_abort) begin
        mon_busy  = 1'b0;
        mon_abort = 1'b0;
      end
      if (!mon_busy) begin
        if (prev_txd === 1'b1 && TxD === 1'b0) begin
          if (exp_q.size() == 0) begin
            check("unexpected_frame", 32'd1, 32'd0);
            cur.data = 8'h00; cur.nbits = 8; cur.par_en = 0; cur.par_odd = 0;
            cur.stop2 = 0; cur.b2b = 0; cur.exp_run = 0;
          end else begin
            cur = exp_q.pop_front();
          end
          frame_bits(cur, ev, elen);
          if (cur.b2b) check("b2b_high_run", hi_run, cur.exp_run);
          mon_busy = 1'b1; cnt = 0; k = 0; rx = '0;
        end
      end else begin
        cnt++;
        if (cnt == 30 + BIT_CLKS * k) begin
          rx[k] = TxD;
          k++;
          if (k == elen) begin
            mask = 16'hFFFF >> (16 - elen);
            check($sformatf("frame_%02h", cur.data), rx & mask, ev & mask);
            mon_busy = 1'b0;
          end
        end
      end
      hi_run   = (TxD === 1'b1) ? hi_run + 1 : 0;
      prev_txd = TxD;
    end
  end

  initial begin
    frame_t fa, fb, none;
    int lows;
    none = '{default: 0};
    bus.CS = 0; bus.R_W = 1; bus.DATA = 0; bus.TX_ENA = 0; bus.TX_DIS = 0;
    set_cfg(2'd3, 0, 0, 0);
    tick(3);
    rst = 1'b0;
    tick(1);
    check("rst_txd", TxD, 1'b1);
    check("rst_txrdy", bus.TxRDY, 1'b0);
    check("rst_txemt", bus.TxEMT, 1'b0);

    pulse_ena_dis(1, 0);
    check("ena_txrdy_early", bus.TxRDY, 1'b0);
    tick(1);
    check("ena_txrdy", bus.TxRDY, 1'b1);
    check("ena_txemt", bus.TxEMT, 1'b1);
    check("ena_txd", TxD, 1'b1);

    // 0x55, 8N1: TxRDY dips for one cycle, TxEMT low for the whole frame.
    fa = make_frame(8'h55, 0, none); exp_q.push_back(fa);
    wr_char(8'h55, 1);
    lows = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.TxRDY !== 1'b1) lows++;
      tick(1);
    end
    check("txrdy_dip_cycles", lows, 1);
    tick(300);
    check("txemt_midframe", bus.TxEMT, 1'b0);
    tick(400);
    check("txemt_after", bus.TxEMT, 1'b1);
    check("txrdy_after", bus.TxRDY, 1'b1);

    // 0x41 then 0x42 back-to-back; 0x43 arrives while THR is full and is lost.
    fa = make_frame(8'h41, 0, none); exp_q.push_back(fa);
    fb = make_frame(8'h42, 1, fa);   exp_q.push_back(fb);
    wr_char(8'h41, 1); tick(3);
    wr_char(8'h42, 1); tick(5);
    wr_char(8'h43, 1);
    tick(2 * 10 * BIT_CLKS + 200);

    // 5-bit parity frames, odd then even, then two stop bits back-to-back.
    set_cfg(2'd0, 1, 1, 0);
    fa = make_frame(8'h07, 0, none); exp_q.push_back(fa);
    wr_char(8'h07, 1); tick(9 * BIT_CLKS + 200);
    set_cfg(2'd0, 1, 0, 0);
    fa = make_frame(8'h07, 0, none); exp_q.push_back(fa);
    wr_char(8'h07, 1); tick(9 * BIT_CLKS + 200);
    set_cfg(2'd0, 1, 0, 1);
    fa = make_frame(8'h07, 0, none); exp_q.push_back(fa);
    fb = make_frame(8'h07, 1, fa);   exp_q.push_back(fb);
    wr_char(8'h07, 1); tick(3);
    wr_char(8'h07, 1); tick(2 * 10 * BIT_CLKS + 200);

    // Disable during bit 3 of 0x33 with 0x44 queued: both still go out.
    set_cfg(2'd3, 0, 0, 0);
    fa = make_frame(8'h33, 0, none); exp_q.push_back(fa);
    fb = make_frame(8'h44, 1, fa);   exp_q.push_back(fb);
    wr_char(8'h33, 1); tick(3);
    wr_char(8'h44, 1); tick(280);
    pulse_ena_dis(0, 1);
    tick(2);
    check("dis_txrdy", bus.TxRDY, 1'b0);
    tick(2 * 10 * BIT_CLKS + 200);
    check("dis_txrdy_after", bus.TxRDY, 1'b0);
    check("dis_txemt_after", bus.TxEMT, 1'b0);
    check("dis_txd_idle", TxD, 1'b1);
    wr_char(8'h99, 1);
    pulse_ena_dis(1, 1);
    tick(3);
    check("ena_dis_same_cycle", bus.TxRDY, 1'b0);
    wr_char(8'h9A, 1);
    tick(12 * BIT_CLKS);

    // Reset mid-DATA aborts the frame; a long CS after re-enable loads once.
    pulse_ena_dis(1, 0);
    tick(2);
    check("reena_txrdy", bus.TxRDY, 1'b1);
    fa = make_frame(8'hA5, 0, none); exp_q.push_back(fa);
    wr_char(8'hA5, 1);
    tick(200);
    rst = 1'b1; mon_abort = 1'b1;
    tick(1);
    rst = 1'b0;
    check("midrst_txd", TxD, 1'b1);
    check("midrst_txrdy", bus.TxRDY, 1'b0);
    check("midrst_txemt", bus.TxEMT, 1'b0);
    tick(BIT_CLKS);
    pulse_ena_dis(1, 0);
    tick(2);
    check("postrst_thr_empty", bus.TxRDY, 1'b1);
    fa = make_frame(8'h5A, 0, none); exp_q.push_back(fa);
    wr_char(8'h5A, 5);
    tick(2 * 10 * BIT_CLKS + 200);

    // Randomized pairs: A, queued B (back-to-back), C dropped while B waits.
    for (int it = 0; it < 8; it++) begin
      set_cfg(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      fa = make_frame(8'($urandom_range(0, 255)), 0, none); exp_q.push_back(fa);
      fb = make_frame(8'($urandom_range(0, 255)), 1, fa);   exp_q.push_back(fb);
      wr_char(fa.data, 1); tick(3);
      wr_char(fb.data, 1); tick($urandom_range(5, 150));
      wr_char(8'($urandom_range(0, 255)), 1);
      tick((frame_len(fa) + frame_len(fb)) * BIT_CLKS);
      check("rand_txemt", bus.TxEMT, 1'b1);
    end

    tick(20);
    check("exp_queue_drained", exp_q.size(), 0);
    check("monitor_idle", mon_busy, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
